// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size mode codes, per-mode schedule sizes,
// GF(2^8) doubling and the round-constant seed used by the key expander.
package aes_pkg;

    localparam int AES_WORD_W = 32;

    typedef enum logic [1:0] {
        MOD_128     = 2'b00,
        MOD_192     = 2'b01,
        MOD_256     = 2'b10,
        MOD_ILLEGAL = 2'b11
    } aes_mod_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } kx_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Key length in 32-bit words.
    function automatic logic [3:0] nk_of(input logic [1:0] m);
        case (m)
            MOD_192: nk_of = 4'd6;
            MOD_256: nk_of = 4'd8;
            default: nk_of = 4'd4;
        endcase
    endfunction

    // Number of expanded words, 4*(Nr+1).
    function automatic logic [5:0] nwords_of(input logic [1:0] m);
        case (m)
            MOD_192: nwords_of = 6'd52;
            MOD_256: nwords_of = 6'd60;
            default: nwords_of = 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES S-box lookups on a 32-bit word; purely combinational,
// shared by the key expander and the cipher's SubBytes stage.
module aes_sbox_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                  SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES key schedule: streams w[0..4(Nr+1)-1] one word per accepted
// beat from a sliding window holding the Nk most recent words.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int KEY_W  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mod,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              rk_ready,
    output logic              rk_valid,
    output logic [WORD_W-1:0] rk_word,
    output logic [5:0]        rk_index,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a beat transfers on any rising edge where rk_valid & rk_ready;
    // rk_word/rk_index are held unchanged until that edge, and rk_valid never
    // drops without a transfer except on reset.

    kx_state_e         r_state;
    kx_state_e         w_state_nxt;
    logic [WORD_W-1:0] r_win [8];
    logic [3:0]        r_nk;
    logic [5:0]        r_nwords;
    logic [5:0]        r_idx;
    logic [2:0]        r_phase;
    logic [7:0]        r_rcon;
    logic              r_err;

    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_accept;
    logic              w_last;
    logic [2:0]        w_top_sel;
    logic [WORD_W-1:0] w_newest;
    logic [WORD_W-1:0] w_sbox_in;
    logic [WORD_W-1:0] w_sbox_out;
    logic [WORD_W-1:0] w_temp;
    logic [WORD_W-1:0] w_next_word;

    assign w_start_ok  = (r_state == ST_IDLE) && start && (mod != MOD_ILLEGAL);
    assign w_start_bad = (r_state == ST_IDLE) && start && (mod == MOD_ILLEGAL);
    assign w_accept    = (r_state == ST_GEN) && rk_ready;
    assign w_last      = (r_idx == r_nwords - 6'd1);
    assign w_top_sel   = 3'(r_nk - 4'd1);

    // While w[i] is presented the window holds w[i..i+Nk-1]; the word
    // generated now is w[i+Nk] = w[i] ^ f(w[i+Nk-1]), and (i+Nk) mod Nk = i mod Nk.
    assign w_newest  = r_win[w_top_sel];
    assign w_sbox_in = (r_phase == 3'd0) ? {w_newest[23:0], w_newest[31:24]} : w_newest;

    aes_sbox_word u_sbox (
        .i_word (w_sbox_in),
        .o_word (w_sbox_out)
    );

    always_comb begin
        w_temp = w_newest;
        if (r_phase == 3'd0) begin
            w_temp = w_sbox_out ^ {r_rcon, 24'h0};
        end else if ((r_nk == 4'd8) && (r_phase == 3'd4)) begin
            w_temp = w_sbox_out;
        end
        w_next_word = r_win[0] ^ w_temp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_state_nxt = ST_GEN;
            ST_GEN:  if (w_accept && w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rk_valid    = (r_state == ST_GEN);
        busy        = (r_state == ST_GEN);
        done        = (r_state == ST_DONE);
        err         = r_err;
        rk_word     = r_win[0];
        rk_index    = r_idx;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) r_win[k] <= '0;
            r_nk     <= 4'd4;
            r_nwords <= 6'd44;
            r_idx    <= 6'd0;
            r_phase  <= 3'd0;
            r_rcon   <= RCON_INIT;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_start_bad;
            if (w_start_ok) begin
                for (int k = 0; k < 8; k++) begin
                    r_win[k] <= key_in[KEY_W-1-WORD_W*k -: WORD_W];
                end
                r_nk     <= nk_of(mod);
                r_nwords <= nwords_of(mod);
                r_idx    <= 6'd0;
                r_phase  <= 3'd0;
                r_rcon   <= RCON_INIT;
            end else if (w_accept) begin
                for (int k = 0; k < 7; k++) begin
                    r_win[k] <= (3'(k) == w_top_sel) ? w_next_word : r_win[k+1];
                end
                r_win[7] <= w_next_word;
                r_idx    <= r_idx + 6'd1;
                r_phase  <= (r_phase == w_top_sel) ? 3'd0 : r_phase + 3'd1;
                if (r_phase == 3'd0) r_rcon <= xtime(r_rcon);
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for the AES key-schedule sequencer using FIPS-197 vectors.
module tb_aes_key_expand_seq;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   mod = 2'b00;
    logic [255:0] key_in = '0;
    logic         rk_ready = 1'b0;
    logic         rk_valid;
    logic [31:0]  rk_word;
    logic [5:0]   rk_index;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] got_w  [64];
    logic [31:0] ref128 [64];
    logic [31:0] ref256 [64];
    int n_beats, done_cyc, first_valid_cyc, last_beat_cyc;
    int idx_bad, stall_bad, n_stalls;

    localparam logic [255:0] KEY_A128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_B128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY_256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes_key_expand_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mod         (mod),
        .key_in      (key_in),
        .rk_ready    (rk_ready),
        .rk_valid    (rk_valid),
        .rk_word     (rk_word),
        .rk_index    (rk_index),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic [255:0] k);
        @(negedge clk);
        start  = 1'b1;
        mod    = m;
        key_in = k;
    endtask

    // Cycle 1 is the first cycle after the edge that sampled start.
    task automatic run_stream(input bit stall, input int abort_at, input int inject_at);
        logic [31:0] prev_word;
        logic [5:0]  prev_idx;
        bit          prev_stall;
        int          cyc;
        prev_word = '0;
        prev_idx = '0;
        prev_stall = 1'b0;
        cyc = 0;
        n_beats = 0; done_cyc = -1; first_valid_cyc = -1; last_beat_cyc = -1;
        idx_bad = 0; stall_bad = 0; n_stalls = 0;
        for (int i = 0; i < 64; i++) got_w[i] = 'x;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                key_in = ~key_in;
                mod    = MOD_ILLEGAL;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (abort_at >= 0 && n_beats == abort_at) break;
            if (prev_stall && (rk_word !== prev_word || rk_index !== prev_idx)) stall_bad++;
            if (inject_at == cyc) begin
                start  = 1'b1;
                mod    = MOD_256;
                key_in = KEY_256;
            end
            rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_stall = 1'b0;
            if (rk_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (rk_ready) begin
                    if (rk_index !== 6'(n_beats)) idx_bad++;
                    got_w[rk_index] = rk_word;
                    n_beats++;
                    last_beat_cyc = cyc;
                end else begin
                    n_stalls++;
                    prev_stall = 1'b1;
                    prev_word  = rk_word;
                    prev_idx   = rk_index;
                end
            end
        end
    endtask

    task automatic check_done_pulse_ends(input string tag);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt_valid, cnt_done, seq_bad;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid_held", 32'(rk_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(rk_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_index", 32'(rk_index), 32'd0);
        check("rst_word",  rk_word, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // 128-bit FIPS C.1 key, full rate, with a stray start during GEN
        do_start(MOD_128, KEY_A128);
        run_stream(1'b0, -1, 10);
        check("a128_first_valid_cyc", 32'(first_valid_cyc), 32'd1);
        check("a128_beats", 32'(n_beats), 32'd44);
        check("a128_last_beat_cyc", 32'(last_beat_cyc), 32'd44);
        check("a128_done_cyc", 32'(done_cyc), 32'd45);
        check("a128_index_seq", 32'(idx_bad), 32'd0);
        check("a128_w0", got_w[0], 32'h00010203);
        check("a128_w3", got_w[3], 32'h0c0d0e0f);
        check("a128_w4", got_w[4], 32'hd6aa74fd);
        check("a128_w5", got_w[5], 32'hd2af72fa);
        check("a128_w43", got_w[43], 32'h4d2b30c5);
        check_done_pulse_ends("a128");
        for (int i = 0; i < 64; i++) ref128[i] = got_w[i];

        // 128-bit FIPS appendix A.1 key
        do_start(MOD_128, KEY_B128);
        run_stream(1'b0, -1, -1);
        check("b128_beats", 32'(n_beats), 32'd44);
        check("b128_w0", got_w[0], 32'h2b7e1516);
        check("b128_w4", got_w[4], 32'ha0fafe17);
        check("b128_w5", got_w[5], 32'h88542cb1);
        check("b128_w43", got_w[43], 32'hb6630ca6);

        // 192-bit
        do_start(MOD_192, KEY_192);
        run_stream(1'b0, -1, -1);
        check("k192_beats", 32'(n_beats), 32'd52);
        check("k192_done_cyc", 32'(done_cyc), 32'd53);
        check("k192_w5", got_w[5], 32'h14151617);
        check("k192_w6", got_w[6], 32'h5846f2f9);
        check("k192_w51", got_w[51], 32'he3a41d5d);

        // 256-bit, no stalls
        do_start(MOD_256, KEY_256);
        run_stream(1'b0, -1, -1);
        check("k256_beats", 32'(n_beats), 32'd60);
        check("k256_done_cyc", 32'(done_cyc), 32'd61);
        check("k256_index_seq", 32'(idx_bad), 32'd0);
        check("k256_w8", got_w[8], 32'ha573c29f);
        check("k256_w12", got_w[12], 32'h1651a8cd);
        check("k256_w59", got_w[59], 32'h6d68de36);
        for (int i = 0; i < 64; i++) ref256[i] = got_w[i];

        // 256-bit with random backpressure
        do_start(MOD_256, KEY_256);
        run_stream(1'b1, -1, -1);
        check("stall_beats", 32'(n_beats), 32'd60);
        check("stall_seen", 32'(n_stalls > 0), 32'd1);
        check("stall_hold_stable", 32'(stall_bad), 32'd0);
        check("stall_index_seq", 32'(idx_bad), 32'd0);
        seq_bad = 0;
        for (int i = 0; i < 60; i++) if (got_w[i] !== ref256[i]) seq_bad++;
        check("stall_seq_same", 32'(seq_bad), 32'd0);
        check("stall_w59", got_w[59], 32'h6d68de36);
        check("stall_done_seen", 32'(done_cyc > 0), 32'd1);

        // Illegal mode
        rk_ready = 1'b1;
        do_start(MOD_ILLEGAL, KEY_256);
        @(negedge clk);
        start = 1'b0;
        check("ill_err_pulse", 32'(err), 32'd1);
        check("ill_busy", 32'(busy), 32'd0);
        check("ill_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        check("ill_err_one_cycle", 32'(err), 32'd0);
        cnt_valid = 0;
        for (int i = 0; i < 6; i++) begin
            if (rk_valid || busy) cnt_valid++;
            @(negedge clk);
        end
        check("ill_no_valid", 32'(cnt_valid), 32'd0);

        // Reset at beat 20 of a 192-bit run
        do_start(MOD_192, KEY_192);
        run_stream(1'b0, 20, -1);
        check("abort_reached_20", 32'(n_beats), 32'd20);
        check("abort_busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_valid_async", 32'(rk_valid), 32'd0);
        check("abort_busy_async", 32'(busy), 32'd0);
        check("abort_index_async", 32'(rk_index), 32'd0);
        check("abort_word_async", rk_word, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt_done = 0;
        cnt_valid = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) cnt_done++;
            if (rk_valid) cnt_valid++;
        end
        check("abort_no_done", 32'(cnt_done), 32'd0);
        check("abort_no_valid", 32'(cnt_valid), 32'd0);

        // Fresh 128-bit run after abort
        do_start(MOD_128, KEY_A128);
        run_stream(1'b0, -1, -1);
        check("fresh_beats", 32'(n_beats), 32'd44);
        check("fresh_done_cyc", 32'(done_cyc), 32'd45);
        check("fresh_w4", got_w[4], 32'hd6aa74fd);
        check("fresh_w43", got_w[43], 32'h4d2b30c5);
        seq_bad = 0;
        for (int i = 0; i < 44; i++) if (got_w[i] !== ref128[i]) seq_bad++;
        check("fresh_seq_same", 32'(seq_bad), 32'd0);
        check_done_pulse_ends("fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
Iterative AES key-schedule sequencer that sits upstream of the AES cipher/decipher cores. It accepts a 128/192/256-bit key and a mode code using the AES top-level `mod` encoding (00=128, 01=192, 10=256). It streams the expanded round-key words w[0..4(Nr+1)-1] one 32-bit word per accepted beat over a valid/ready handshake, and the cores buffer the words into their round-key storage.

Parameters:
- WORD_W, 32, round-key word width (fixed by AES; not to be overridden).
- KEY_W, 256, key input width; shorter keys are MSB-aligned.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin expansion; sampled only in IDLE.
- mod  in  2  key size: 00=128, 01=192, 10=256, 11=illegal. Sampled with start.
- key_in  in  256  cipher key, MSB-aligned. 128-bit uses [255:128]; 192-bit uses [255:64]. Sampled with start.
- rk_ready  in  1  consumer accepts the word this cycle.
- rk_valid  out  1  rk_word/rk_index are valid.
- rk_word  out  32  expanded word w[i].
- rk_index  out  6  i, range 0..59.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted.
- err  out  1  one-cycle pulse when start is sampled with mod=11.

Behaviour:
- Reset (asynchronous, active-high, any state): FSM goes to IDLE; rk_valid, busy, done, err, rk_index = 0; rk_word = 0; window cleared; rcon = 8'h01.
- Derived constants per mode: Nk = 4/6/8; total words = 44/52/60.
- States:
  - IDLE: start & mod!=11 → latch key into an 8-word window, latch Nk → GEN. start & mod==11 → err=1 for one cycle, stay IDLE.
  - GEN: rk_valid=1. On rk_valid & rk_ready, advance i. On acceptance of the last word (i = total-1) → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Latency: start accepted at cycle 0 → rk_valid=1 with w[0] at cycle 1. With rk_ready held high, one word per cycle: 128-bit last word at cycle 44, done at cycle 45. 192-bit: cycles 52/53. 256-bit: cycles 60/61.
- Word generation:
  - i < Nk: w[i] = key word i, taken MSB-first.
  - i ≥ Nk: temp = w[i-1].
    - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon ← xtime(rcon) (80→1b).
    - Else if Nk==8 and i mod 8 == 4: temp = SubWord(temp).
    - w[i] = w[i-Nk] ^ temp.
- "i mod Nk" is tracked by a wrapping counter (0..Nk-1); no divider.
- The next word is computed combinationally from the window and registered into rk_word on acceptance, so the following beat has zero bubbles.
- Backpressure: while rk_valid & !rk_ready, rk_word and rk_index hold stable and no state advances.
- start while busy or in DONE is ignored; key_in and mod changes after the start cycle have no effect.
- A reset mid-stream aborts the expansion: rk_valid drops immediately and no done pulse is issued.

Decomposition:
- Shared package aes_pkg holds:
  - mode encodings MOD_128/MOD_192/MOD_256/MOD_ILLEGAL;
  - functions nk_of(mod) and nwords_of(mod);
  - xtime function;
  - Rcon initial value.
- One sub-module: aes_sbox_word, a purely combinational 4× S-box lookup on 32 bits. It is shared with the cipher core's SubBytes.

Test Plan:
- mod=00, key 000102030405060708090a0b0c0d0e0f, rk_ready=1 → w[4]=d6aa74fd, w[43]=4d2b30c5; 44 beats; done at cycle 45.
- mod=00, key 2b7e151628aed2a6abf7158809cf4f3c → w[4]=a0fafe17, w[43]=b6630ca6.
- mod=01, key 000102…1617 → w[51]=e3a41d5d; 52 beats. mod=10, key 000102…1e1f → w[59]=6d68de36; 60 beats.
- Random rk_ready toggling in 256-bit mode → rk_word/rk_index stable while stalled; sequence identical to the no-stall run.
- mod=11 start → err pulse for one cycle, busy stays 0, rk_valid never asserts. start during GEN → ignored.
- Assert reset at beat 20 of a 192-bit run → outputs cleared asynchronously, no done pulse. A fresh 128-bit start afterwards yields the correct w[0..43].
